riscv_register_file_mp: RTL and testbench
=========================================

# riscv_register_file_mp

Multi-port, flip-flop based integer register file with a per-register busy scoreboard. It generalises the fixed 3-read/2-write core register file:
- read and write port counts are parameters;
- hardwiring of register 0 is optional;
- an optional write-to-read bypass is available.

It sits between decode (reads, busy marking for long-latency ops) and writeback (writes, busy clearing) in the RI5CY-class pipeline.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width; NUM_WORDS = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NUM_RPORTS, 3, read ports (1..8)
- NUM_WPORTS, 2, write ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, 1: same-cycle write data and busy-clear are forwarded to read ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- raddr_i  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, packed the same way
- rbusy_o  out  NUM_RPORTS  busy flag of the register addressed by each read port
- waddr_i  in  NUM_WPORTS*ADDR_WIDTH  write addresses
- wdata_i  in  NUM_WPORTS*DATA_WIDTH  write data
- we_i  in  NUM_WPORTS  write enables
- mark_i  in  1  set busy for mark_addr_i (long-latency op issued)
- mark_addr_i  in  ADDR_WIDTH  register to mark busy
- any_busy_o  out  1  OR of all busy bits

## Operation
- State: NUM_WORDS x DATA_WIDTH data registers and NUM_WORDS busy bits.
  - With ZERO_REG=1, register 0 is constant 0 and its busy bit is constant 0; it needs no flops.
- Write decode: the per-port one-hot enable for word i is we_i[p] & (waddr_p == i).
- Write collision: when several ports target one word in the same cycle, the highest-indexed port wins. The others are dropped silently.
- Busy update per word, evaluated at each clock edge:
  - if mark hits the word, busy is set;
  - else if any write hits the word, busy is cleared;
  - else busy holds.
  - Mark and write to the same word in the same cycle: the data is written AND busy stays set, because a new op is outstanding.
- Read, BYPASS=0: rdata_o[k] = reg[raddr_k] and rbusy_o[k] = busy[raddr_k]. Both are purely combinational from state.
- Read, BYPASS=1: if any enabled write targets raddr_k this cycle, rdata_o[k] is the winning write data and rbusy_o[k] = 0. This does not apply to a zero register; it also does not apply when mark_i targets the same address, in which case rbusy_o[k] = 1.
- Reads of register 0 with ZERO_REG=1 always return 0 with rbusy 0, even when written or marked.
- ZERO_REG=1: mark_i to register 0 is ignored.
- Out-of-range parameter values stop elaboration with $error.

## Timing
- Reset (async assert, sync-safe deassert by the system): all data registers 0, all busy bits 0.
  - Outputs during/after reset: rdata_o all 0, rbusy_o all 0, any_busy_o 0.
- Write latency:
  - BYPASS=0: data is visible on reads in the cycle after we_i.
  - BYPASS=1: data is visible in the same cycle, combinational path waddr/wdata -> rdata.
- Mark latency: busy is visible on rbusy_o/any_busy_o in the cycle after mark_i. There is no same-cycle forwarding, except the BYPASS collision rule above.
- Reset asserted mid-operation clears every data register and busy bit immediately. Pending writes in that cycle are lost.
- Throughput: every port can be used every cycle. There is no stall or backpressure inside the block.

## Test plan
- Reset, then read all 32 addresses on all ports -> rdata 0, rbusy 0, any_busy_o 0.
- BYPASS=0: write 0xDEADBEEF to r5 on port 0, read r5 the same cycle -> old value 0; next cycle -> 0xDEADBEEF.
- BYPASS=1: same stimulus -> 0xDEADBEEF in the same cycle.
- Ports 0 and 1 write r7 with 0x11111111 and 0x22222222 in the same cycle -> r7 = 0x22222222.
- ZERO_REG=1: write 0xFFFFFFFF to r0 and mark r0 -> reads return 0, rbusy 0.
- Mark r3; next cycle rbusy for r3 = 1 and any_busy_o = 1. Write r3 -> BYPASS=1 gives rbusy 0 the same cycle; then the next cycle gives rbusy 0 and any_busy_o 0. Mark and write r3 together -> busy remains 1 and the data is updated.
- Mark r9, then assert rst_n low mid-cycle -> busy and data are cleared at once, with no clock edge required.

Source files
------------

// File: rtl/riscv_register_file_mp_if.sv
// Register file port bundle: read ports, write ports, busy marking.
// Master side is the pipeline (decode/writeback), slave is the register file.
interface riscv_register_file_mp_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2
);
  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i;
  logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
  logic [NUM_RPORTS-1:0]            rbusy_o;
  logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i;
  logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
  logic [NUM_WPORTS-1:0]            we_i;
  logic                             mark_i;
  logic [ADDR_WIDTH-1:0]            mark_addr_i;
  logic                             any_busy_o;

  modport master (
    output raddr_i, waddr_i, wdata_i, we_i,
    output mark_i, mark_addr_i,
    input  rdata_o, rbusy_o, any_busy_o
  );

  modport slave (
    input  raddr_i, waddr_i, wdata_i, we_i,
    input  mark_i, mark_addr_i,
    output rdata_o, rbusy_o, any_busy_o
  );
endinterface

// File: rtl/riscv_register_file_mp.sv
// Multi-port flop-based integer register file with busy scoreboard.
// Optional hardwired r0 and optional write-to-read bypass.
module riscv_register_file_mp #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 3,
  parameter int NUM_WPORTS = 2,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                      clk,
  input logic                      rst_n,
  riscv_register_file_mp_if.slave  bus
);

  localparam int NUM_WORDS = 2**ADDR_WIDTH;

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("ADDR_WIDTH must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_dw
    $error("DATA_WIDTH must be >= 1");
  end
  if (NUM_RPORTS < 1 || NUM_RPORTS > 8) begin : g_bad_rp
    $error("NUM_RPORTS must be 1..8");
  end
  if (NUM_WPORTS < 1 || NUM_WPORTS > 4) begin : g_bad_wp
    $error("NUM_WPORTS must be 1..4");
  end
  if (ZERO_REG != 0 && ZERO_REG != 1) begin : g_bad_zr
    $error("ZERO_REG must be 0 or 1");
  end
  if (BYPASS != 0 && BYPASS != 1) begin : g_bad_bp
    $error("BYPASS must be 0 or 1");
  end

  logic [NUM_WORDS-1:0]  wr_hit;
  logic [NUM_WORDS-1:0]  mark_hit;
  logic [DATA_WIDTH-1:0] wr_data [NUM_WORDS];
  logic [DATA_WIDTH-1:0] rf_data [NUM_WORDS];
  logic [NUM_WORDS-1:0]  rf_busy;

  // Per-word write/mark decode; later ports overwrite earlier ones
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      wr_hit[i]   = 1'b0;
      wr_data[i]  = '0;
      mark_hit[i] = bus.mark_i &&
                    (bus.mark_addr_i == ADDR_WIDTH'(i));
      for (int p = 0; p < NUM_WPORTS; p++) begin
        if (bus.we_i[p] &&
            bus.waddr_i[p*ADDR_WIDTH +: ADDR_WIDTH]
              == ADDR_WIDTH'(i)) begin
          wr_hit[i]  = 1'b1;
          wr_data[i] = bus.wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    if (ZERO_REG != 0) begin
      wr_hit[0]   = 1'b0;
      mark_hit[0] = 1'b0;
      wr_data[0]  = '0;
    end
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    if (ZERO_REG != 0 && i == 0) begin : g_zero
      assign rf_data[i] = '0;
      assign rf_busy[i] = 1'b0;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] data_q, data_d;
      logic                  busy_q, busy_d;

      // Next state: mark wins over write-clear on busy
      always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        if (wr_hit[i]) data_d = wr_data[i];
        if (mark_hit[i]) busy_d = 1'b1;
        else if (wr_hit[i]) busy_d = 1'b0;
      end

      // Word state register
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign rf_data[i] = data_q;
      assign rf_busy[i] = busy_q;
    end
  end

  logic [ADDR_WIDTH-1:0] ra;
  logic [DATA_WIDTH-1:0] rd;
  logic                  rb;

  // Read muxes with optional same-cycle write forwarding
  always_comb begin
    bus.rdata_o = '0;
    bus.rbusy_o = '0;
    ra = '0;
    rd = '0;
    rb = 1'b0;
    for (int k = 0; k < NUM_RPORTS; k++) begin
      ra = bus.raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      rd = rf_data[ra];
      rb = rf_busy[ra];
      if (BYPASS != 0 && wr_hit[ra]) begin
        rd = wr_data[ra];
        rb = mark_hit[ra];
      end
      bus.rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = rd;
      bus.rbusy_o[k] = rb;
    end
  end

  assign bus.any_busy_o = |rf_busy;

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed bench for riscv_register_file_mp.
// Two instances share stimulus: one with bypass, one without.
module tb_riscv_register_file_mp;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int NW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  riscv_register_file_mp_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_RPORTS(NR), .NUM_WPORTS(NW)
  ) if_b ();
  riscv_register_file_mp_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_RPORTS(NR), .NUM_WPORTS(NW)
  ) if_n ();

  assign if_n.raddr_i     = if_b.raddr_i;
  assign if_n.waddr_i     = if_b.waddr_i;
  assign if_n.wdata_i     = if_b.wdata_i;
  assign if_n.we_i        = if_b.we_i;
  assign if_n.mark_i      = if_b.mark_i;
  assign if_n.mark_addr_i = if_b.mark_addr_i;

  riscv_register_file_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_RPORTS(NR), .NUM_WPORTS(NW),
    .ZERO_REG(1), .BYPASS(1)
  ) u_byp (
    .clk(clk), .rst_n(rst_n), .bus(if_b.slave)
  );

  riscv_register_file_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_RPORTS(NR), .NUM_WPORTS(NW),
    .ZERO_REG(1), .BYPASS(0)
  ) u_nob (
    .clk(clk), .rst_n(rst_n), .bus(if_n.slave)
  );

  function automatic logic [DW-1:0] rdb(int k);
    return if_b.rdata_o[k*DW +: DW];
  endfunction
  function automatic logic [DW-1:0] rdn(int k);
    return if_n.rdata_o[k*DW +: DW];
  endfunction
  function automatic logic bsb(int k);
    return if_b.rbusy_o[k];
  endfunction
  function automatic logic bsn(int k);
    return if_n.rbusy_o[k];
  endfunction

  task automatic idle();
    if_b.raddr_i     = '0;
    if_b.waddr_i     = '0;
    if_b.wdata_i     = '0;
    if_b.we_i        = '0;
    if_b.mark_i      = 1'b0;
    if_b.mark_addr_i = '0;
  endtask

  task automatic rd(int k, logic [AW-1:0] a);
    if_b.raddr_i[k*AW +: AW] = a;
  endtask

  task automatic wr(int p, logic [AW-1:0] a, logic [DW-1:0] d);
    if_b.we_i[p] = 1'b1;
    if_b.waddr_i[p*AW +: AW] = a;
    if_b.wdata_i[p*DW +: DW] = d;
  endtask

  task automatic mk(logic [AW-1:0] a);
    if_b.mark_i = 1'b1;
    if_b.mark_addr_i = a;
  endtask

  task automatic next();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #1;
    for (int a = 0; a < 32; a++) begin
      for (int k = 0; k < NR; k++) rd(k, AW'(a));
      #1;
      for (int k = 0; k < NR; k++) begin
        n_cmp += 4;
        if (rdb(k) !== 32'h0) begin
          n_err++;
          $display("FAIL reset_rdata_byp a=%0d k=%0d got %h exp 0", a, k, rdb(k));
        end
        if (rdn(k) !== 32'h0) begin
          n_err++;
          $display("FAIL reset_rdata_nob a=%0d k=%0d got %h exp 0", a, k, rdn(k));
        end
        if (bsb(k) !== 1'b0) begin
          n_err++;
          $display("FAIL reset_rbusy_byp a=%0d k=%0d got %b exp 0", a, k, bsb(k));
        end
        if (bsn(k) !== 1'b0) begin
          n_err++;
          $display("FAIL reset_rbusy_nob a=%0d k=%0d got %b exp 0", a, k, bsn(k));
        end
      end
    end
    n_cmp += 2;
    if (if_b.any_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_any_byp got %b exp 0", if_b.any_busy_o);
    end
    if (if_n.any_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_any_nob got %b exp 0", if_n.any_busy_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_write_latency();
    next();
    idle();
    wr(0, 5, 32'hDEADBEEF);
    rd(0, 5);
    #1;
    n_cmp += 2;
    if (rdb(0) !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wlat_same_byp got %h exp deadbeef", rdb(0));
    end
    if (rdn(0) !== 32'h0) begin
      n_err++;
      $display("FAIL wlat_same_nob got %h exp 0", rdn(0));
    end
    next();
    idle();
    rd(0, 5);
    #1;
    n_cmp += 2;
    if (rdb(0) !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wlat_next_byp got %h exp deadbeef", rdb(0));
    end
    if (rdn(0) !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL wlat_next_nob got %h exp deadbeef", rdn(0));
    end
  endtask

  task automatic test_collision();
    next();
    idle();
    wr(0, 7, 32'h11111111);
    wr(1, 7, 32'h22222222);
    rd(1, 7);
    #1;
    n_cmp += 2;
    if (rdb(1) !== 32'h22222222) begin
      n_err++;
      $display("FAIL coll_same_byp got %h exp 22222222", rdb(1));
    end
    if (rdn(1) !== 32'h0) begin
      n_err++;
      $display("FAIL coll_same_nob got %h exp 0", rdn(1));
    end
    next();
    idle();
    rd(1, 7);
    #1;
    n_cmp += 2;
    if (rdb(1) !== 32'h22222222) begin
      n_err++;
      $display("FAIL coll_next_byp got %h exp 22222222", rdb(1));
    end
    if (rdn(1) !== 32'h22222222) begin
      n_err++;
      $display("FAIL coll_next_nob got %h exp 22222222", rdn(1));
    end
  endtask

  task automatic test_zero_reg();
    next();
    idle();
    wr(0, 0, 32'hFFFFFFFF);
    mk(0);
    rd(2, 0);
    #1;
    n_cmp += 2;
    if (rdb(2) !== 32'h0 || bsb(2) !== 1'b0) begin
      n_err++;
      $display("FAIL zero_same_byp got %h/%b exp 0/0", rdb(2), bsb(2));
    end
    if (rdn(2) !== 32'h0 || bsn(2) !== 1'b0) begin
      n_err++;
      $display("FAIL zero_same_nob got %h/%b exp 0/0", rdn(2), bsn(2));
    end
    next();
    idle();
    rd(2, 0);
    #1;
    n_cmp += 3;
    if (rdb(2) !== 32'h0 || bsb(2) !== 1'b0) begin
      n_err++;
      $display("FAIL zero_next_byp got %h/%b exp 0/0", rdb(2), bsb(2));
    end
    if (rdn(2) !== 32'h0 || bsn(2) !== 1'b0) begin
      n_err++;
      $display("FAIL zero_next_nob got %h/%b exp 0/0", rdn(2), bsn(2));
    end
    if (if_b.any_busy_o !== 1'b0 || if_n.any_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL zero_any got %b/%b exp 0/0", if_b.any_busy_o, if_n.any_busy_o);
    end
  endtask

  task automatic test_busy();
    next();
    idle();
    mk(3);
    rd(0, 3);
    #1;
    n_cmp += 1;
    if (bsb(0) !== 1'b0 || bsn(0) !== 1'b0) begin
      n_err++;
      $display("FAIL mark_same got %b/%b exp 0/0", bsb(0), bsn(0));
    end
    next();
    idle();
    rd(0, 3);
    #1;
    n_cmp += 2;
    if (bsb(0) !== 1'b1 || bsn(0) !== 1'b1) begin
      n_err++;
      $display("FAIL mark_next got %b/%b exp 1/1", bsb(0), bsn(0));
    end
    if (if_b.any_busy_o !== 1'b1 || if_n.any_busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mark_any got %b/%b exp 1/1", if_b.any_busy_o, if_n.any_busy_o);
    end
    wr(1, 3, 32'h33333333);
    #1;
    n_cmp += 3;
    if (bsb(0) !== 1'b0 || rdb(0) !== 32'h33333333) begin
      n_err++;
      $display("FAIL clr_same_byp got %b/%h exp 0/33333333", bsb(0), rdb(0));
    end
    if (bsn(0) !== 1'b1) begin
      n_err++;
      $display("FAIL clr_same_nob got %b exp 1", bsn(0));
    end
    if (rdn(0) !== 32'h0) begin
      n_err++;
      $display("FAIL clr_same_nob_data got %h exp 0", rdn(0));
    end
    next();
    idle();
    rd(0, 3);
    #1;
    n_cmp += 2;
    if (bsb(0) !== 1'b0 || bsn(0) !== 1'b0) begin
      n_err++;
      $display("FAIL clr_next got %b/%b exp 0/0", bsb(0), bsn(0));
    end
    if (if_b.any_busy_o !== 1'b0 || if_n.any_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL clr_any got %b/%b exp 0/0", if_b.any_busy_o, if_n.any_busy_o);
    end
    mk(3);
    wr(0, 3, 32'h44444444);
    #1;
    n_cmp += 2;
    if (bsb(0) !== 1'b1 || rdb(0) !== 32'h44444444) begin
      n_err++;
      $display("FAIL mkwr_same_byp got %b/%h exp 1/44444444", bsb(0), rdb(0));
    end
    if (bsn(0) !== 1'b0 || rdn(0) !== 32'h33333333) begin
      n_err++;
      $display("FAIL mkwr_same_nob got %b/%h exp 0/33333333", bsn(0), rdn(0));
    end
    next();
    idle();
    rd(0, 3);
    #1;
    n_cmp += 3;
    if (bsb(0) !== 1'b1 || bsn(0) !== 1'b1) begin
      n_err++;
      $display("FAIL mkwr_busy got %b/%b exp 1/1", bsb(0), bsn(0));
    end
    if (rdb(0) !== 32'h44444444 || rdn(0) !== 32'h44444444) begin
      n_err++;
      $display("FAIL mkwr_data got %h/%h exp 44444444", rdb(0), rdn(0));
    end
    if (if_n.any_busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL mkwr_any got %b exp 1", if_n.any_busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] adr [3];
    adr[0] = 5'd1;
    adr[1] = 5'd2;
    adr[2] = 5'd4;
    for (int c = 0; c < 3; c++) begin
      next();
      idle();
      wr(c % 2, adr[c], 32'hA0 + c);
      for (int k = 0; k < NR; k++) rd(k, adr[k]);
    end
    #1;
    n_cmp += 2;
    if (rdb(2) !== 32'hA2 || rdn(2) !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_last got %h/%h exp a2/0", rdb(2), rdn(2));
    end
    if (rdb(0) !== 32'hA0 || rdn(0) !== 32'hA0) begin
      n_err++;
      $display("FAIL b2b_r1 got %h/%h exp a0/a0", rdb(0), rdn(0));
    end
    next();
    idle();
    for (int k = 0; k < NR; k++) rd(k, adr[k]);
    #1;
    for (int k = 0; k < NR; k++) begin
      n_cmp++;
      if (rdb(k) !== 32'hA0 + k || rdn(k) !== 32'hA0 + k) begin
        n_err++;
        $display("FAIL b2b_final k=%0d got %h/%h exp %h", k, rdb(k), rdn(k), 32'hA0 + k);
      end
    end
  endtask

  task automatic test_async_reset();
    next();
    idle();
    mk(9);
    wr(0, 10, 32'hA5A5A5A5);
    next();
    idle();
    rd(0, 9);
    rd(1, 10);
    #1;
    n_cmp += 2;
    if (bsb(0) !== 1'b1 || bsn(0) !== 1'b1) begin
      n_err++;
      $display("FAIL ar_pre_busy got %b/%b exp 1/1", bsb(0), bsn(0));
    end
    if (rdb(1) !== 32'hA5A5A5A5 || rdn(1) !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL ar_pre_data got %h/%h exp a5a5a5a5", rdb(1), rdn(1));
    end
    wr(0, 11, 32'h12345678);
    rst_n = 1'b0;
    #1;
    n_cmp += 3;
    if (bsb(0) !== 1'b0 || bsn(0) !== 1'b0) begin
      n_err++;
      $display("FAIL ar_busy got %b/%b exp 0/0", bsb(0), bsn(0));
    end
    if (rdb(1) !== 32'h0 || rdn(1) !== 32'h0) begin
      n_err++;
      $display("FAIL ar_data got %h/%h exp 0/0", rdb(1), rdn(1));
    end
    if (if_b.any_busy_o !== 1'b0 || if_n.any_busy_o !== 1'b0) begin
      n_err++;
      $display("FAIL ar_any got %b/%b exp 0/0", if_b.any_busy_o, if_n.any_busy_o);
    end
    next();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    rd(1, 11);
    #1;
    n_cmp += 1;
    if (rdb(1) !== 32'h0 || rdn(1) !== 32'h0) begin
      n_err++;
      $display("FAIL ar_lost_wr got %h/%h exp 0/0", rdb(1), rdn(1));
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_write_latency();
    test_collision();
    test_zero_reg();
    test_busy();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
